// File: rtl/gm_pkg.sv
// gm_pkg: shared constants, cell codes and FSM state for the GM refresh link.
// Optional feature macro: GM_TX_CHECKSUM_EN (sweep checksum port on gm_transmitter).
package gm_pkg;

    localparam int CELLS = 256;
    localparam int AW    = 8;
    localparam int DW    = 4;
    localparam int CW    = 4;
    localparam int SW    = 8;

    localparam logic [DW-1:0] CODE_FLAG         = 4'h1;
    localparam int            CODE_REVEALED_BIT = 3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        HOLD
    } gm_state_e;

    // Address step that parks on the final cell instead of wrapping.
    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? a : a + 1'b1;
    endfunction

endpackage

// File: rtl/gm_transmitter.sv
// gm_transmitter: streams the board RAM to the pixel generator during retrace.
// Define GM_TX_CHECKSUM_EN to add the sweep_sum checksum output.
module gm_transmitter
    import gm_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          request,
    output logic [AW-1:0] brd_addr,
    input  logic [DW-1:0] brd_data,
    input  logic [CW-1:0] cur_x_in,
    input  logic [CW-1:0] cur_y_in,
    output logic [AW-1:0] GMaddress,
    output logic [DW-1:0] GMdata,
    output logic [CW-1:0] current_x,
    output logic [CW-1:0] current_y,
    output logic          done,
`ifdef GM_TX_CHECKSUM_EN
    output logic [SW-1:0] sweep_sum,
`endif
    output logic          abort
);

    gm_state_e     state_q, state_d;
    logic [AW-1:0] brd_addr_q, brd_addr_d;
    logic [AW-1:0] pipe_addr_q, pipe_addr_d;
    logic [AW-1:0] gm_addr_q, gm_addr_d;
    logic [DW-1:0] gm_data_q, gm_data_d;
    logic [CW-1:0] cur_x_q, cur_x_d;
    logic [CW-1:0] cur_y_q, cur_y_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic          final_pair;

`ifdef GM_TX_CHECKSUM_EN
    logic [SW-1:0] acc_q, acc_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-1:0] acc_next;

    assign acc_next = acc_q + {{(SW-DW){1'b0}}, brd_data};
`endif

    assign final_pair = (pipe_addr_q == LAST_ADDR);

    // Sweep sequencer: next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        brd_addr_d  = brd_addr_q;
        pipe_addr_d = pipe_addr_q;
        gm_addr_d   = gm_addr_q;
        gm_data_d   = gm_data_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
`ifdef GM_TX_CHECKSUM_EN
        acc_d       = acc_q;
        sum_d       = sum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (request) begin
                    state_d    = PRIME;
                    brd_addr_d = '0;
`ifdef GM_TX_CHECKSUM_EN
                    acc_d      = '0;
`endif
                end
            end
            PRIME: begin
                if (!request) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d     = STREAM;
                    brd_addr_d  = AW'(1);
                    pipe_addr_d = '0;
                end
            end
            STREAM: begin
                // Losing the window on the last pair still completes the sweep.
                if (!request && !final_pair) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    gm_addr_d   = pipe_addr_q;
                    gm_data_d   = brd_data;
                    brd_addr_d  = sat_inc(brd_addr_q);
                    pipe_addr_d = sat_inc(pipe_addr_q);
`ifdef GM_TX_CHECKSUM_EN
                    acc_d       = acc_next;
`endif
                    if (final_pair) begin
                        done_d  = 1'b1;
                        cur_x_d = cur_x_in;
                        cur_y_d = cur_y_in;
                        state_d = request ? HOLD : IDLE;
`ifdef GM_TX_CHECKSUM_EN
                        sum_d   = acc_next;
`endif
                    end
                end
            end
            HOLD: begin
                if (!request) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            brd_addr_q  <= '0;
            pipe_addr_q <= '0;
            gm_addr_q   <= '0;
            gm_data_q   <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
`ifdef GM_TX_CHECKSUM_EN
            acc_q       <= '0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            brd_addr_q  <= brd_addr_d;
            pipe_addr_q <= pipe_addr_d;
            gm_addr_q   <= gm_addr_d;
            gm_data_q   <= gm_data_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
`ifdef GM_TX_CHECKSUM_EN
            acc_q       <= acc_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign brd_addr  = brd_addr_q;
    assign GMaddress = gm_addr_q;
    assign GMdata    = gm_data_q;
    assign current_x = cur_x_q;
    assign current_y = cur_y_q;
    assign done      = done_q;
    assign abort     = abort_q;
`ifdef GM_TX_CHECKSUM_EN
    assign sweep_sum = sum_q;
`endif

endmodule

// File: tb/tb_gm_transmitter.sv
// tb_gm_transmitter: randomized retrace frames against a frame-level model.
// Expected pairs/done/abort are queued by stimulus and popped by a monitor.
module tb_gm_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       request;
    logic [7:0] brd_addr;
    logic [3:0] brd_data;
    logic [3:0] cin_x, cin_y;
    logic [7:0] GMaddress;
    logic [3:0] GMdata;
    logic [3:0] current_x, current_y;
    logic       done, abort;
`ifdef GM_TX_CHECKSUM_EN
    logic [7:0] sweep_sum;
`endif

    gm_transmitter dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .brd_addr  (brd_addr),
        .brd_data  (brd_data),
        .cur_x_in  (cin_x),
        .cur_y_in  (cin_y),
        .GMaddress (GMaddress),
        .GMdata    (GMdata),
        .current_x (current_x),
        .current_y (current_y),
        .done      (done),
`ifdef GM_TX_CHECKSUM_EN
        .sweep_sum (sweep_sum),
`endif
        .abort     (abort)
    );

    always #5 clk = ~clk;

    logic [3:0] board [256];
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) brd_data <= board[brd_addr];

    typedef struct {
        int         cyc;
        bit         is_done;
        bit         is_abort;
        logic [7:0] a;
        logic [3:0] d;
        logic [3:0] cx;
        logic [3:0] cy;
        logic [7:0] sum;
    } exp_t;

    exp_t q[$];
    bit   mon_en = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [7:0] m_a = 0;
    logic [3:0] m_d = 0;
    logic [3:0] m_cx = 0, m_cy = 0;
    logic [7:0] m_sum = 0;

    task automatic chk(input string nm, input int unsigned act,
                       input int unsigned expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, expv);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_brd_addr"}, brd_addr, 0);
        chk({nm, "_gmaddress"}, GMaddress, 0);
        chk({nm, "_gmdata"}, GMdata, 0);
        chk({nm, "_current_x"}, current_x, 0);
        chk({nm, "_current_y"}, current_y, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_abort"}, abort, 0);
`ifdef GM_TX_CHECKSUM_EN
        chk({nm, "_sweep_sum"}, sweep_sum, 0);
`endif
    endtask

    // Monitor: pop every expectation due this cycle and compare.
    initial begin
        exp_t e;
        bit   ed, ea;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                ed = 0;
                ea = 0;
                while (q.size() != 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    if (e.cyc < cyc) begin
                        chk("missed_event_cycle", cyc, e.cyc);
                    end else begin
                        if (e.is_done)  ed = 1;
                        if (e.is_abort) ea = 1;
                        chk("gmaddress", GMaddress, e.a);
                        chk("gmdata", GMdata, e.d);
                        chk("current_x", current_x, e.cx);
                        chk("current_y", current_y, e.cy);
`ifdef GM_TX_CHECKSUM_EN
                        chk("sweep_sum", sweep_sum, e.sum);
`endif
                    end
                end
                chk("done", done, ed);
                chk("abort", abort, ea);
            end
        end
    end

    // One retrace window: request high for h edges then low for l edges.
    // Cursor inputs change to (nx,ny) at offset cc within the window.
    task automatic frame(input int h, input int l, input int cc,
                         input logic [3:0] nx, input logic [3:0] ny);
        int         e0, np;
        logic [3:0] lx, ly;
        logic [7:0] s;
        exp_t       e;
        e0 = cyc + 1;
        np = (h >= 257) ? 256 : ((h >= 2) ? h - 2 : 0);
        lx = (cc <= 257) ? nx : cin_x;
        ly = (cc <= 257) ? ny : cin_y;
        s  = 0;
        for (int i = 0; i < 256; i++) s = s + 8'(board[i]);
        for (int k = 0; k < np; k++) begin
            e.cyc      = e0 + 2 + k;
            e.is_done  = (k == 255);
            e.is_abort = 0;
            e.a        = 8'(k);
            e.d        = board[k];
            e.cx       = e.is_done ? lx : m_cx;
            e.cy       = e.is_done ? ly : m_cy;
            e.sum      = e.is_done ? s : m_sum;
            q.push_back(e);
        end
        if (np > 0) begin
            m_a = 8'(np - 1);
            m_d = board[np-1];
        end
        if (np == 256) begin
            m_cx  = lx;
            m_cy  = ly;
            m_sum = s;
        end else begin
            e.cyc      = e0 + h;
            e.is_done  = 0;
            e.is_abort = 1;
            e.a        = m_a;
            e.d        = m_d;
            e.cx       = m_cx;
            e.cy       = m_cy;
            e.sum      = m_sum;
            q.push_back(e);
        end
        for (int t = 0; t < h + l; t++) begin
            request = (t < h);
            if (t == cc) begin
                cin_x = nx;
                cin_y = ny;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int h;
        rst     = 1;
        request = 0;
        cin_x   = 0;
        cin_y   = 0;
        for (int i = 0; i < 256; i++) board[i] = 4'(i) ^ 4'h5;

        repeat (3) @(negedge clk);
        chk_zero("reset");

        rst     = 0;
        request = 1;
        cin_x   = 3;
        cin_y   = 7;
        repeat (50) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk_zero("reset_mid_sweep");

        rst    = 0;
        mon_en = 1;
        frame(300, 5, 100, 4'd9, 4'd2);

        frame(100, 5, 1000, 4'd0, 4'd0);
        frame(270, 3, 1000, 4'd0, 4'd0);

        frame(257, 4, 50, 4'd12, 4'd5);
        frame(258, 2, 258, 4'd1, 4'd1);
        frame(1, 3, 1000, 4'd0, 4'd0);
        frame(2, 3, 1000, 4'd0, 4'd0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) board[i] = 4'($urandom);
            h = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30)
                                            : $urandom_range(240, 300);
            frame(h, $urandom_range(2, 12), $urandom_range(0, 310),
                  4'($urandom), 4'($urandom));
        end

`ifdef GM_TX_CHECKSUM_EN
        for (int i = 0; i < 256; i++) board[i] = 4'hF;
        frame(260, 3, 1000, 4'd0, 4'd0);
        for (int i = 0; i < 256; i++) board[i] = 4'h1;
        frame(260, 3, 1000, 4'd0, 4'd0);
        for (int i = 0; i < 256; i++) board[i] = 4'h0;
        board[0] = 4'h3;
        frame(260, 3, 1000, 4'd0, 4'd0);
`endif

        for (int w = 0; w < 400 && q.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drained_left", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
